video_in_pack_fifo: RTL and testbench



---
 rtl/video_in_pack_fifo.sv | 164 ++++++++++++++++
 tb/tb_video_in_pack_fifo.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/video_in_pack_fifo.sv
// Packs 8-bit camera pixels into 32-bit words and buffers them in a show-ahead FIFO for the store stage.
// Define VIDEO_IN_PACK_FIFO_LEVEL_EN to add the fifo_level / max_level occupancy outputs.
module video_in_pack_fifo #(
  parameter int p_WIDTH    = 640,
  parameter int p_HEIGHT   = 480,
  parameter int NB_PACK    = 16,
  parameter int FIFO_DEPTH = 64
) (
  input  logic        clk,
  input  logic        nRST,
  input  logic [7:0]  pixel_in,
  input  logic        line_valid,
  input  logic        frame_valid,
  input  logic        new_addr,
  input  logic        r_ack,
  output logic [31:0] data_fifo,
  output logic        nb_pack_available,
  output logic        overflow
`ifdef VIDEO_IN_PACK_FIFO_LEVEL_EN
  ,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic [$clog2(FIFO_DEPTH):0] max_level
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [19:0] PIX_TOTAL = 20'(p_WIDTH * p_HEIGHT);

  typedef enum logic [1:0] {IDLE, WAIT_FRAME, CAPTURE, DONE} state_t;

  state_t        state;
  logic          fv_prev;
  logic [1:0]    lane;
  logic [23:0]   pack;
  logic [19:0]   pix_cnt;
  logic [31:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [AW:0]   count;

  logic          accept;
  logic          word_done;
  logic [31:0]   word;
  logic          pop_ok;
  logic          push_ok;
  logic          full;
  logic [AW-1:0] rptr_next;
  logic [AW:0]   count_next;
  logic [31:0]   head_next;

  always_comb begin
    accept     = (state == CAPTURE) && frame_valid && line_valid;
    word_done  = accept && (lane == 2'd3);
    word       = {pixel_in, pack};
    pop_ok     = r_ack && (count != '0);
    full       = (count == CW'(FIFO_DEPTH));
    push_ok    = word_done && (!full || pop_ok);
    rptr_next  = pop_ok ? rptr + AW'(1) : rptr;
    count_next = count;
    case ({push_ok, pop_ok})
      2'b10:   count_next = count + CW'(1);
      2'b01:   count_next = count - CW'(1);
      default: count_next = count;
    endcase
    // A word written this cycle into the slot that becomes the head bypasses the RAM.
    if (push_ok && (wptr == rptr_next))
      head_next = word;
    else
      head_next = mem[rptr_next];
  end

  always_ff @(posedge clk) begin
    if (push_ok && !new_addr)
      mem[wptr] <= word;
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      case (lane)
        2'd0:    pack[7:0]   <= pixel_in;
        2'd1:    pack[15:8]  <= pixel_in;
        2'd2:    pack[23:16] <= pixel_in;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!nRST) begin
      state             <= IDLE;
      fv_prev           <= 1'b0;
      lane              <= 2'd0;
      pix_cnt           <= 20'd0;
      wptr              <= '0;
      rptr              <= '0;
      count             <= '0;
      overflow          <= 1'b0;
      nb_pack_available <= 1'b0;
      data_fifo         <= 32'd0;
    end else begin
      fv_prev <= frame_valid;
      if (new_addr) begin
        state             <= WAIT_FRAME;
        lane              <= 2'd0;
        pix_cnt           <= 20'd0;
        wptr              <= '0;
        rptr              <= '0;
        count             <= '0;
        overflow          <= 1'b0;
        nb_pack_available <= 1'b0;
        data_fifo         <= 32'd0;
      end else begin
        if (push_ok)
          wptr <= wptr + AW'(1);
        rptr              <= rptr_next;
        count             <= count_next;
        nb_pack_available <= (count_next >= CW'(NB_PACK));
        data_fifo         <= head_next;
        if (word_done && !push_ok)
          overflow <= 1'b1;
        case (state)
          IDLE: ;
          WAIT_FRAME: begin
            if (frame_valid && !fv_prev) begin
              state   <= CAPTURE;
              lane    <= 2'd0;
              pix_cnt <= 20'd0;
            end
          end
          CAPTURE: begin
            // Early end of frame: the partial word is dropped and capture re-arms.
            if (!frame_valid) begin
              state   <= WAIT_FRAME;
              lane    <= 2'd0;
              pix_cnt <= 20'd0;
            end else if (line_valid) begin
              lane    <= lane + 2'd1;
              pix_cnt <= pix_cnt + 20'd1;
              if (pix_cnt + 20'd1 == PIX_TOTAL)
                state <= DONE;
            end
          end
          DONE: ;
          default: state <= IDLE;
        endcase
      end
    end
  end

`ifdef VIDEO_IN_PACK_FIFO_LEVEL_EN
  assign fifo_level = count;

  always_ff @(posedge clk) begin
    if (!nRST)
      max_level <= '0;
    else if (new_addr)
      max_level <= '0;
    else if (count_next > max_level)
      max_level <= count_next;
  end
`endif

endmodule

// File: tb/tb_video_in_pack_fifo.sv
// Directed bench for video_in_pack_fifo using a reduced 32x16 frame so full-frame runs stay short.
module tb_video_in_pack_fifo;

  localparam int W     = 32;
  localparam int H     = 16;
  localparam int NB    = 16;
  localparam int DEPTH = 64;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic        clk = 1'b0;
  logic        nRST;
  logic [7:0]  pixel_in;
  logic        line_valid;
  logic        frame_valid;
  logic        new_addr;
  logic        r_ack;
  logic [31:0] data_fifo;
  logic        nb_pack_available;
  logic        overflow;
`ifdef VIDEO_IN_PACK_FIFO_LEVEL_EN
  logic [LW-1:0] fifo_level;
  logic [LW-1:0] max_level;
`endif

  int vec_cnt = 0;
  int err_cnt = 0;
  int pops;
  logic [31:0] q[$];

  always #5 clk = ~clk;

  video_in_pack_fifo #(
    .p_WIDTH(W), .p_HEIGHT(H), .NB_PACK(NB), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .nRST(nRST),
    .pixel_in(pixel_in),
    .line_valid(line_valid),
    .frame_valid(frame_valid),
    .new_addr(new_addr),
    .r_ack(r_ack),
    .data_fifo(data_fifo),
    .nb_pack_available(nb_pack_available),
    .overflow(overflow)
`ifdef VIDEO_IN_PACK_FIFO_LEVEL_EN
    ,
    .fifo_level(fifo_level),
    .max_level(max_level)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] pix(input int i);
    return 8'((i / 4) + (i % 4) * 64);
  endfunction

  function automatic logic [31:0] word_of(input int k);
    return {8'(k + 192), 8'(k + 128), 8'(k + 64), 8'(k)};
  endfunction

  function automatic logic [31:0] seq_word(input int k);
    return {8'(4 * k + 4), 8'(4 * k + 3), 8'(4 * k + 2), 8'(4 * k + 1)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic arm();
    new_addr = 1'b1;
    tick();
    new_addr = 1'b0;
  endtask

  task automatic frame_start();
    frame_valid = 1'b0;
    line_valid  = 1'b0;
    tick();
    frame_valid = 1'b1;
    tick();
    tick();
  endtask

  task automatic push_pix(input logic [7:0] v);
    pixel_in   = v;
    line_valid = 1'b1;
    tick();
    line_valid = 1'b0;
  endtask

  task automatic pop();
    r_ack = 1'b1;
    tick();
    r_ack = 1'b0;
  endtask

  // One cycle of the streaming test: r_ack is held high, so any queued word is consumed.
  task automatic t2_cycle(input bit lv, input int idx);
    if (q.size() > 0) begin
      chk("t2_pop", data_fifo, q[0]);
      void'(q.pop_front());
      pops++;
    end
    pixel_in   = pix(idx);
    line_valid = lv;
    tick();
    if (lv && (idx % 4 == 3))
      q.push_back(word_of(idx / 4));
  endtask

  initial begin
    nRST = 1'b0; pixel_in = 8'd0; line_valid = 1'b0; frame_valid = 1'b0;
    new_addr = 1'b0; r_ack = 1'b0;
    tick();
    tick();
    chk("rst_data", data_fifo, 32'd0);
    chk("rst_nb", 32'(nb_pack_available), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
`ifdef VIDEO_IN_PACK_FIFO_LEVEL_EN
    chk("rst_level", 32'(fifo_level), 32'd0);
    chk("rst_max", 32'(max_level), 32'd0);
`endif
    nRST = 1'b1;
    tick();

    // Packing order and nb_pack_available threshold timing
    arm();
    frame_start();
    for (int i = 0; i < 64; i++) begin
      push_pix(8'(i + 1));
      if (i == 7) chk("t1_head_w0", data_fifo, 32'h04030201);
      if (i == 62) chk("t1_nb_63px", 32'(nb_pack_available), 32'd0);
      if (i == 63) chk("t1_nb_64px", 32'(nb_pack_available), 32'd1);
    end
    pop();
    chk("t1_head_w1", data_fifo, 32'h08070605);
    chk("t1_nb_after_pop", 32'(nb_pack_available), 32'd0);
    for (int k = 2; k < 16; k++) begin
      pop();
      chk("t1_word", data_fifo, seq_word(k));
    end

    // Full frame streamed out with r_ack held high
    arm();
    frame_start();
    pops = 0;
    q.delete();
    r_ack = 1'b1;
    for (int i = 0; i < W * H; i++) begin
      if ((i % W == 0) && (i != 0)) begin
        t2_cycle(1'b0, 0);
        t2_cycle(1'b0, 0);
      end
      t2_cycle(1'b1, i);
    end
    repeat (4) t2_cycle(1'b0, 0);
    r_ack = 1'b0;
    chk("t2_pop_count", 32'(pops), 32'(W * H / 4));
    chk("t2_ovf", 32'(overflow), 32'd0);
    chk("t2_nb", 32'(nb_pack_available), 32'd0);
    frame_start();
    for (int i = 0; i < 64; i++) push_pix(pix(i));
    chk("t2_done_ignores", 32'(nb_pack_available), 32'd0);

    // new_addr mid-frame flushes and skips the rest of that frame
    arm();
    frame_start();
    for (int i = 0; i < 14; i++) push_pix(8'(8'hC0 + i));
    pixel_in = 8'hEE;
    line_valid = 1'b1;
    new_addr = 1'b1;
    tick();
    new_addr = 1'b0;
    chk("t3_nb_flush", 32'(nb_pack_available), 32'd0);
`ifdef VIDEO_IN_PACK_FIFO_LEVEL_EN
    chk("t3_level_flush", 32'(fifo_level), 32'd0);
`endif
    for (int i = 0; i < 64; i++) push_pix(8'hEE);
    chk("t3_rest_ignored", 32'(nb_pack_available), 32'd0);
    frame_valid = 1'b0;
    tick();
    frame_valid = 1'b1;
    tick();
    tick();
    for (int i = 0; i < 64; i++) begin
      push_pix(pix(i));
      if (i == 3) chk("t3_new_head", data_fifo, word_of(0));
      if (i == 59) chk("t3_nb_60px", 32'(nb_pack_available), 32'd0);
      if (i == 63) chk("t3_nb_64px", 32'(nb_pack_available), 32'd1);
    end

    // Overflow: 65 words without popping
    arm();
    frame_start();
    for (int i = 0; i < 260; i++) begin
      push_pix(pix(i));
      if (i == 255) chk("t4_ovf_at_64", 32'(overflow), 32'd0);
    end
    chk("t4_ovf", 32'(overflow), 32'd1);
    chk("t4_nb", 32'(nb_pack_available), 32'd1);
`ifdef VIDEO_IN_PACK_FIFO_LEVEL_EN
    chk("t4_level", 32'(fifo_level), 32'd64);
    chk("t4_max", 32'(max_level), 32'd64);
`endif
    for (int k = 0; k < 64; k++) begin
      chk("t4_pop", data_fifo, word_of(k));
      pop();
    end
    chk("t4_nb_empty", 32'(nb_pack_available), 32'd0);
    chk("t4_ovf_sticky", 32'(overflow), 32'd1);
    for (int i = 260; i < 264; i++) push_pix(pix(i));
    chk("t4_word64_absent", data_fifo, word_of(65));

    // Push and pop together on a full FIFO, then pop on empty
    arm();
    chk("t5_ovf_cleared", 32'(overflow), 32'd0);
    frame_start();
    for (int i = 0; i < 259; i++) push_pix(pix(i));
    pixel_in = pix(259);
    line_valid = 1'b1;
    r_ack = 1'b1;
    tick();
    line_valid = 1'b0;
    r_ack = 1'b0;
    chk("t5_ovf", 32'(overflow), 32'd0);
    chk("t5_nb", 32'(nb_pack_available), 32'd1);
`ifdef VIDEO_IN_PACK_FIFO_LEVEL_EN
    chk("t5_level", 32'(fifo_level), 32'd64);
`endif
    for (int k = 1; k <= 64; k++) begin
      chk("t5_pop", data_fifo, word_of(k));
      pop();
    end
    chk("t5_nb_empty", 32'(nb_pack_available), 32'd0);
    pop();
    chk("t5_empty_pop_nb", 32'(nb_pack_available), 32'd0);
`ifdef VIDEO_IN_PACK_FIFO_LEVEL_EN
    chk("t5_empty_pop_level", 32'(fifo_level), 32'd0);
`endif
    for (int i = 260; i < 264; i++) push_pix(pix(i));
    chk("t5_after_empty", data_fifo, word_of(65));
    chk("t5_ovf_end", 32'(overflow), 32'd0);

    // Early end of frame discards the partial word
    arm();
    frame_start();
    for (int i = 0; i < 6; i++) push_pix(8'(8'h11 + i));
    frame_valid = 1'b0;
    tick();
    chk("t6_head", data_fifo, 32'h14131211);
`ifdef VIDEO_IN_PACK_FIFO_LEVEL_EN
    chk("t6_level", 32'(fifo_level), 32'd1);
    chk("t6_max", 32'(max_level), 32'd1);
`endif
    frame_valid = 1'b1;
    tick();
    tick();
    for (int i = 0; i < 4; i++) push_pix(8'(8'h21 + i));
    pop();
    chk("t6_next_frame", data_fifo, 32'h24232221);
    frame_valid = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
